// File: rtl/ws2812_chain.sv
// WS2812 chain driver: one frame per start; first ws rise 2 cycles after the first pixel handshake, frame closed by a latch period.
// Pixels are pulled through a one-entry prefetch buffer (ready only while empty); a source starved for a full latch time aborts the frame.
module ws2812_chain #(
    parameter int ClkFreqMhz = 70,
    parameter int NumLeds    = 8,
    parameter int BitsPerLed = 24,
    parameter int T0hNs      = 400,
    parameter int T1hNs      = 800,
    parameter int BitNs      = 1250,
    parameter int LatchNs    = 80000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_underrun,
    input  logic                  i_pix_valid,
    output logic                  o_pix_ready,
    input  logic [BitsPerLed-1:0] i_pix_data,
    output logic                  o_ws
);
    localparam int T0H    = ClkFreqMhz * T0hNs / 1000;
    localparam int T1H    = ClkFreqMhz * T1hNs / 1000;
    localparam int TBIT   = ClkFreqMhz * BitNs / 1000;
    localparam int TLATCH = ClkFreqMhz * LatchNs / 1000;
    localparam int TMAX   = (TBIT > TLATCH) ? TBIT : TLATCH;
    localparam int CW     = $clog2(TMAX + 1);
    localparam int PW     = $clog2(NumLeds + 1);
    localparam int BW     = $clog2(BitsPerLed);

    localparam logic [CW-1:0] C_T0H_M1    = CW'(T0H - 1);
    localparam logic [CW-1:0] C_T1H_M1    = CW'(T1H - 1);
    localparam logic [CW-1:0] C_TBIT_M1   = CW'(TBIT - 1);
    localparam logic [CW-1:0] C_TLATCH_M1 = CW'(TLATCH - 1);
    localparam logic [PW-1:0] C_NUM_LEDS  = PW'(NumLeds);
    localparam logic [BW-1:0] C_LAST_BIT  = BW'(BitsPerLed - 1);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
        $error("ws2812_chain: bit timing must satisfy 0 < T0H < T1H < TBIT");
    end

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HIGH, S_LOW, S_LATCH} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_fetch_left;
    logic [PW-1:0]         r_tx_left;
    logic [BW-1:0]         r_bit;
    logic [BitsPerLed-1:0] r_shift;
    logic [BitsPerLed-1:0] r_buf;
    logic                  r_buf_full;
    logic                  r_ws;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_underrun;
    logic                  w_hs;
    logic                  w_high_end;

    assign o_pix_ready = r_busy && !r_buf_full && (r_fetch_left != '0);
    assign w_hs        = i_pix_valid && o_pix_ready;
    assign w_high_end  = r_shift[BitsPerLed-1] ? (r_cnt == C_T1H_M1) : (r_cnt == C_T0H_M1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_fetch_left <= '0;
            r_tx_left    <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_buf        <= '0;
            r_buf_full   <= 1'b0;
            r_ws         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            if (w_hs) begin
                r_buf        <= i_pix_data;
                r_buf_full   <= 1'b1;
                r_fetch_left <= r_fetch_left - 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_WAIT;
                        r_busy       <= 1'b1;
                        r_fetch_left <= C_NUM_LEDS;
                        r_tx_left    <= C_NUM_LEDS;
                        r_buf_full   <= 1'b0;
                        r_cnt        <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_buf_full) begin
                        r_shift    <= r_buf;
                        r_buf_full <= 1'b0;
                        r_bit      <= '0;
                        r_cnt      <= '0;
                        r_ws       <= 1'b1;
                        r_state    <= S_HIGH;
                    end else if (r_cnt == C_TLATCH_M1) begin
                        // Starved source: abort and stop pulling pixels for this frame.
                        r_underrun   <= 1'b1;
                        r_fetch_left <= '0;
                        r_cnt        <= '0;
                        r_state      <= S_LATCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_high_end) begin
                        r_ws    <= 1'b0;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (r_cnt == C_TBIT_M1) begin
                        r_shift <= r_shift << 1;
                        r_cnt   <= '0;
                        if (r_bit == C_LAST_BIT) begin
                            r_tx_left <= r_tx_left - 1'b1;
                            if (r_tx_left == PW'(1)) begin
                                r_state <= S_LATCH;
                            end else if (r_buf_full) begin
                                r_shift    <= r_buf;
                                r_buf_full <= 1'b0;
                                r_bit      <= '0;
                                r_ws       <= 1'b1;
                                r_state    <= S_HIGH;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_ws    <= 1'b1;
                            r_state <= S_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == C_TLATCH_M1) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ws       = r_ws;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_underrun = r_underrun;
endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain at 20 MHz, 3 x 32-bit pixels: handshaken pixels feed a queue, ws is decoded bit by bit against it.
module tb_ws2812_chain;
    localparam int B      = 32;
    localparam int NLEDS  = 3;
    localparam int T0H    = 8;
    localparam int T1H    = 16;
    localparam int TBIT   = 25;
    localparam int TLATCH = 1600;
    localparam int FRAME  = 3 + NLEDS * B * TBIT + TLATCH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, underrun, pix_ready, ws;
    logic         pix_valid;
    logic [B-1:0] pix_data;

    int           cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_hs = 0, n_und = 0, n_done = 0;
    int           und_cyc = 0, first_rise = -1;
    int           s = 0, hs0 = 0, u0 = 0, d0 = 0;
    logic [B-1:0] sb[$];
    logic [B-1:0] src_pix[3];
    int           src_from[3];
    logic         src_go = 1'b0;

    ws2812_chain #(
        .ClkFreqMhz(20), .NumLeds(NLEDS), .BitsPerLed(B),
        .T0hNs(400), .T1hNs(800), .BitNs(1250), .LatchNs(80000)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(busy), .o_done(done), .o_underrun(underrun),
        .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
        .i_pix_data(pix_data), .o_ws(ws)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Pixel source: offers pixel k from cycle src_from[k] onward.
    initial begin : source
        int k;
        k = 0;
        pix_valid = 1'b0;
        pix_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (!src_go) begin
                k = 0;
                pix_valid = 1'b0;
            end else if (k < NLEDS) begin
                pix_valid = (cyc >= src_from[k]);
                pix_data  = src_pix[k];
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
            if (pix_valid && pix_ready) k++;
        end
    end

    // Monitor: scoreboard push on handshake, decode ws against the queue head.
    initial begin : monitor
        int           rise_cyc, bit_idx, w;
        logic         ws_q;
        logic [B-1:0] cur_exp, acc;
        rise_cyc = 0; bit_idx = 0; ws_q = 1'b0; cur_exp = '0; acc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                bit_idx = 0;
                ws_q = 1'b0;
            end else begin
                if (start && !busy) first_rise = -1;
                if (pix_valid && pix_ready) begin
                    sb.push_back(pix_data);
                    n_hs++;
                end
                if (underrun) begin
                    n_und++;
                    und_cyc = cyc;
                end
                if (done) n_done++;
                if (ws && !ws_q) begin
                    if (bit_idx == 0) begin
                        if (sb.size() == 0) check("sb_underflow", 0, 1);
                        else cur_exp = sb.pop_front();
                    end else begin
                        check("bit_period", cyc - rise_cyc, TBIT);
                    end
                    if (first_rise < 0) first_rise = cyc;
                    rise_cyc = cyc;
                end
                if (!ws && ws_q) begin
                    w = cyc - rise_cyc;
                    check("high_time", w, cur_exp[B-1-bit_idx] ? T1H : T0H);
                    acc = {acc[B-2:0], (w > (T0H + T1H) / 2)};
                    bit_idx++;
                    if (bit_idx == B) begin
                        check("pixel", acc, cur_exp);
                        bit_idx = 0;
                    end
                end
                ws_q = ws;
            end
        end
    end

    task automatic launch(input logic [B-1:0] p0, input logic [B-1:0] p1, input logic [B-1:0] p2,
                          input int f1, input int f2);
        @(posedge clk); #2;
        s = cyc;
        src_pix  = '{p0, p1, p2};
        src_from = '{s + 1, s + f1, s + f2};
        hs0 = n_hs; u0 = n_und; d0 = n_done;
        src_go = 1'b1;
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        check("busy_rise", busy, 1);
        check("ready_rise", pix_ready, 1);
    endtask

    task automatic finish_frame(input int done_off, input int hs_exp, input int und_exp);
        int dc;
        dc = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) check("done_timeout", 0, 1);
        else check("done_cycle", dc - s, done_off);
        check("busy_fall", busy, 0);
        check("first_rise", first_rise - s, 3);
        check("handshakes", n_hs - hs0, hs_exp);
        check("underruns", n_und - u0, und_exp);
        check("sb_drained", sb.size(), 0);
        src_go = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin : main
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ws", ws, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", pix_ready, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Always-valid frame, with a stray start in the middle.
        launch(32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 1, 1);
        repeat (500) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_stray_start", busy, 1);
        finish_frame(FRAME, 3, 0);

        // Pixel 2 arrives 99 cycles after pixel 1's last Low cycle: 100-cycle gap.
        launch(32'hA500_0000, 32'h1234_5678, 32'hDEAD_BEEF, 1, 1701);
        finish_frame(FRAME + 100, 3, 0);

        // Pixel 2 never arrives in time: underrun, then a full latch.
        launch(32'h0F0F_0F0F, 32'hC3C3_C3C3, 32'h5555_AAAA, 1, 100000);
        finish_frame(4803, 2, 1);
        check("underrun_cycle", und_cyc - s, 3203);

        // Fresh frame after the underrun.
        launch($urandom, $urandom, $urandom, 1, 1);
        finish_frame(FRAME, 3, 0);

        // Reset while ws is high during the first bit.
        launch(32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 1, 1);
        while (cyc < s + 6) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("ws_before_rst", ws, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        src_go = 1'b0;
        @(negedge clk);
        check("rst_mid_ws", ws, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", pix_ready, 0);
        d0 = n_done;
        repeat (2000) @(posedge clk);
        check("no_done_after_rst", n_done - d0, 0);

        launch(32'h00FF_00FF, 32'h8765_4321, 32'hFFFF_0000, 1, 1);
        finish_frame(FRAME, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
